// File: rtl/rtc_cnt.sv
// rtc_cnt: prescaled 32-bit real-time counter with alarm, overflow flag, level irq and c_* register bus
module rtc_cnt #(
    parameter int               PSC_W   = 16,
    parameter logic [PSC_W-1:0] PSC_RST = '0
) (
    input  logic        c_clk,
    input  logic        c_rstb,
    output logic [31:0] rtc,
    output logic        irq,
    output logic        c_ready,
    output logic [31:0] c_rdata,
    input  logic [31:0] c_wdata,
    input  logic        c_write,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_size,
    input  logic        c_valid
);
    logic [PSC_W-1:0] pcnt, prescale;
    logic [31:0] alarm, wmask, wd, rword;
    logic [4:0] sh;
    logic en, alarm_ie, ovf_ie, alarm_flag, ovf_flag;
    logic we, sel_ctrl, sel_psc, sel_cnt, sel_alm, sel_sts, clr, load, psc_wr, tick, quiet;
    always_comb begin
        sh       = {c_addr[1:0], 3'b000};
        wmask    = (c_size == 2'd0 ? 32'h0000_00FF : c_size == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        wd       = c_wdata << sh;
        we       = c_valid & c_write;
        sel_ctrl = c_addr[31:2] == 30'd0;
        sel_psc  = c_addr[31:2] == 30'd1;
        sel_cnt  = c_addr[31:2] == 30'd2;
        sel_alm  = c_addr[31:2] == 30'd3;
        sel_sts  = c_addr[31:2] == 30'd4;
        clr      = we & sel_ctrl & wmask[3] & wd[3];
        load     = we & sel_cnt;
        psc_wr   = we & sel_psc & |wmask[PSC_W-1:0];
        tick     = en & (pcnt == prescale);
        quiet    = clr | load;
        rword    = sel_ctrl ? {29'd0, ovf_ie, alarm_ie, en} :
                   sel_psc  ? 32'(prescale) :
                   sel_cnt  ? rtc :
                   sel_alm  ? alarm :
                   sel_sts  ? {30'd0, ovf_flag, alarm_flag} : 32'd0;
    end
    always_ff @(posedge c_clk) begin
        if (!c_rstb) begin
            rtc        <= '0;
            pcnt       <= '0;
            prescale   <= PSC_RST;
            en         <= 1'b1;
            alarm_ie   <= 1'b0;
            ovf_ie     <= 1'b0;
            alarm      <= 32'hFFFF_FFFF;
            alarm_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            c_ready    <= 1'b0;
            c_rdata    <= '0;
            irq        <= 1'b0;
        end else begin
            c_ready <= c_valid;
            c_rdata <= (c_valid & ~c_write) ? rword >> sh : 32'd0;
            if (quiet | psc_wr)
                pcnt <= '0;
            else if (en)
                pcnt <= tick ? '0 : pcnt + 1'b1;
            if (clr)
                rtc <= '0;
            else if (load)
                rtc <= (rtc & ~wmask) | (wd & wmask);
            else if (tick)
                rtc <= rtc + 32'd1;
            if (we & sel_ctrl)
                {ovf_ie, alarm_ie, en} <= ({ovf_ie, alarm_ie, en} & ~wmask[2:0]) | (wd[2:0] & wmask[2:0]);
            if (we & sel_psc)
                prescale <= (prescale & ~wmask[PSC_W-1:0]) | (wd[PSC_W-1:0] & wmask[PSC_W-1:0]);
            if (we & sel_alm)
                alarm <= (alarm & ~wmask) | (wd & wmask);
            // a set event in the same cycle as its W1C wins
            alarm_flag <= (tick & ~quiet & (rtc + 32'd1 == alarm)) |
                          (alarm_flag & ~(we & sel_sts & wmask[0] & wd[0]));
            ovf_flag   <= (tick & ~quiet & (&rtc)) |
                          (ovf_flag & ~(we & sel_sts & wmask[1] & wd[1]));
            irq        <= (alarm_flag & alarm_ie) | (ovf_flag & ovf_ie);
        end
    end
endmodule

// File: doc/rtc_cnt.md
Name: rtc_cnt

Overview:
- Free-running 32-bit real-time counter with a programmable prescaler, an alarm compare and an overflow flag.
- Its count drives the rtc[31:0] vector consumed by the clock generation unit, both as selectable divided-clock sources and as a readable timestamp.
- It also raises a level interrupt.
- Registers are reached over the same c_* configuration bus used by the other bus peripherals.

Parameters:
- PSC_W, 16, prescaler width in bits.
- PSC_RST, 0, prescaler reset value (0 = count advances every c_clk).

Ports:
- c_clk  input  1  configuration/counter clock.
- c_rstb  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- rtc  output  32  current count value (register output, no logic after flop).
- irq  output  1  level interrupt.
- c_ready  output  1  bus response, one cycle after c_valid.
- c_rdata  output  32  read data, byte-lane shifted right by 8*c_addr[1:0].
- c_wdata  input  32  write data, byte-lane shifted left by 8*c_addr[1:0] internally.
- c_write  input  1  1 = write, 0 = read.
- c_addr  input  32  byte address; word decode on c_addr&~3.
- c_size  input  2  0 = byte, 1 = half, 2/3 = word.
- c_valid  input  1  request strobe.

Behaviour:
- Reset (c_rstb low at a c_clk edge), all values:
  - rtc = 0, pcnt = 0, prescale = PSC_RST.
  - en = 1, alarm_ie = 0, ovf_ie = 0.
  - alarm = 32'hFFFFFFFF, alarm_flag = 0, ovf_flag = 0.
  - c_ready = 0, internal rdata register = 0, irq = 0.
- Bus handshake:
  - c_ready <= c_valid every cycle.
  - Read data is registered on the c_valid cycle and presented with c_ready, so read latency is 1.
  - Unmapped addresses read 0; writes to them are ignored.
  - Back-to-back c_valid is allowed.
- Write mask: ((1 << (8 << c_size)) - 1) << (8*c_addr[1:0]), truncated to 32 bits. Only masked bits of a register are updated; read returns the whole word shifted.
- Register map (word offsets):
  - 0x00 CTRL: bit0 en, bit1 alarm_ie, bit2 ovf_ie, bit3 clr. clr is write-only, reads 0. Writing clr=1 zeroes rtc and pcnt in the next cycle.
  - 0x04 PRESCALE: [PSC_W-1:0]. Any write that touches it also zeroes pcnt.
  - 0x08 COUNT: read = rtc. A write loads the masked bits into rtc and zeroes pcnt.
  - 0x0C ALARM: 32-bit compare value.
  - 0x10 STATUS: bit0 alarm_flag, bit1 ovf_flag. Writing 1 clears the flag (W1C).
- Prescaler and counter, every c_clk while en = 1:
  - If pcnt == prescale: pcnt <= 0 and tick = 1. Otherwise pcnt <= pcnt + 1.
  - On tick, rtc <= rtc + 1, wrapping modulo 2^32.
  - On a tick where rtc == 32'hFFFFFFFF, set ovf_flag.
  - On a tick where rtc + 1 == alarm, set alarm_flag. Only the tick transition arms the alarm; loading COUNT equal to ALARM does not set the flag.
  - en = 0 freezes both pcnt and rtc.
- Priority in a single cycle, highest first: reset > COUNT write / clr > tick.
  - A bus load or clear suppresses that cycle's increment and flag setting.
- Flag W1C coinciding with a set event in the same cycle: set wins, flag stays 1.
- irq = (alarm_flag & alarm_ie) | (ovf_flag & ovf_ie). It is registered, so it rises one cycle after the flag.
- Shrinking PRESCALE below the current pcnt is safe, because the write zeroes pcnt.
- Reset mid-transaction: the pending c_ready is dropped; no register is written.

Test Plan:
1. Reset, PSC_RST = 0, no bus traffic for 10 cycles:
   - rtc increments each cycle from 0 and reads 10 at cycle 10.
   - A read of 0x08 returns the value registered on the c_valid cycle, with c_ready one cycle later.
2. Write PRESCALE = 3 (word), then observe:
   - rtc advances once every 4 c_clk.
   - A byte write of 0x01 at address 0x05 changes prescale to 0x0103 and restarts pcnt at 0.
3. Write COUNT = 0xFFFFFFFE, CTRL = 0x5 (en, ovf_ie), prescale 0:
   - rtc goes FFFFFFFF then 00000000.
   - STATUS.ovf_flag = 1 and irq rises one cycle after the flag.
   - Writing STATUS = 0x2 clears the flag and irq.
4. ALARM = 0x20, alarm_ie = 1:
   - alarm_flag sets on the tick where rtc becomes 0x20, and irq asserts.
   - Loading COUNT = 0x20 directly does not set the flag.
   - W1C of alarm_flag on the same cycle as a new alarm tick leaves the flag set.
5. Write COUNT = 0x100 on the same cycle a tick is due:
   - rtc = 0x100 (no increment applied).
   - CTRL.en = 0 freezes rtc at 0x100 for 20 cycles; re-enabling resumes counting.
6. Assert c_rstb low for one cycle mid-count with irq high and a pending read:
   - Next cycle rtc = 0, irq = 0, c_ready = 0.
   - All register reads return their reset values.
